gate_response_checker: RTL



---
 rtl/gate_chk_pkg.sv | 20 ++
 rtl/gate_response_checker_sat_counter.sv | 20 ++
 rtl/gate_response_checker.sv | 124 ++++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and helpers for the gate response checker.
// Golden table layout: entry i holds {Y1,Y2,Y3} for {A,B}=i.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [11:0] GOLD_AND_OR_XOR = 12'hCD8;

  function automatic logic [2:0] exp_y(
    input logic [11:0] tbl,
    input logic [1:0]  ab
  );
    return tbl[3*ab +: 3];
  endfunction

endpackage

// File: rtl/gate_response_checker_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + 1'b1;
  end

endmodule

// File: rtl/gate_response_checker.sv
// Checks sampled gate responses against a golden truth table,
// counting vectors/mismatches and flagging pass, fail or timeout.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int          NUM_VECTORS = 4,
  parameter logic [11:0] EXP_TABLE   = GOLD_AND_OR_XOR,
  parameter int          CNT_W       = 8,
  parameter int          TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [1:0]       vec_ab,
  input  logic [2:0]       vec_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       first_err_ab,
  output logic [2:0]       first_err_y
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  VEC_LAST  = CNT_W'(NUM_VECTORS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              accept;
  logic              mismatch;
  logic              launch;
  logic              last_vec;
  logic              idle_expire;

  assign accept      = vec_valid && vec_ready;
  assign mismatch    = vec_y != exp_y(EXP_TABLE, vec_ab);
  assign launch      = start && (state != RUN);
  assign last_vec    = vec_count == VEC_LAST;
  // An accept on the final idle cycle takes priority over the abort
  assign idle_expire = (state == RUN) && !accept
                       && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if ((accept && last_vec) || idle_expire)
          state_nxt = DONE;
      end
      DONE: if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vec_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      RUN: begin
        vec_ready = 1'b1;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  sat_counter #(.WIDTH(CNT_W)) u_vec_cnt (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .inc (accept),
    .q   (vec_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .inc (accept && mismatch),
    .q   (err_count)
  );

  sat_counter #(.WIDTH(IDLE_W)) u_idle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (launch || accept),
    .inc ((state == RUN) && !accept),
    .q   (idle_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst || launch) begin
      timeout      <= 1'b0;
      first_err_ab <= '0;
      first_err_y  <= '0;
    end else begin
      if (idle_expire)
        timeout <= 1'b1;
      if (accept && mismatch && (err_count == '0)) begin
        first_err_ab <= vec_ab;
        first_err_y  <= vec_y;
      end
    end
  end

  assign pass = done && (err_count == '0) && !timeout;

endmodule
